// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if
//   Bundles the display, pixel-writer and frame-buffer memory signals of
//   vga_fb_arbiter.
//   slave  modport : arbiter view (drives pix_data, underflow, fifo_level,
//                    wr_ack and the mem_* strobe/address/data)
//   master modport : environment view (display timing, writer, RAM model)
//   Optional: FB_UNDERFLOW_CNT_EN adds underflow_cnt[15:0] (arbiter output).
interface vga_fb_arbiter_if #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 16
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              frame_start;
  logic              pix_req;
  logic [DATA_W-1:0] pix_data;
  logic              underflow;
  logic [LVL_W-1:0]  fifo_level;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
`ifdef FB_UNDERFLOW_CNT_EN
  logic [15:0]       underflow_cnt;

  modport slave (
    input  frame_start, pix_req, wr_req, wr_addr, wr_data, mem_rdata,
    output pix_data, underflow, fifo_level, wr_ack,
           mem_en, mem_we, mem_addr, mem_wdata, underflow_cnt
  );
  modport master (
    output frame_start, pix_req, wr_req, wr_addr, wr_data, mem_rdata,
    input  pix_data, underflow, fifo_level, wr_ack,
           mem_en, mem_we, mem_addr, mem_wdata, underflow_cnt
  );
`else
  modport slave (
    input  frame_start, pix_req, wr_req, wr_addr, wr_data, mem_rdata,
    output pix_data, underflow, fifo_level, wr_ack,
           mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output frame_start, pix_req, wr_req, wr_addr, wr_data, mem_rdata,
    input  pix_data, underflow, fifo_level, wr_ack,
           mem_en, mem_we, mem_addr, mem_wdata
  );
`endif
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
//   Shares one single-port frame-buffer RAM between the VGA display fetch
//   (through a prefetch FIFO) and a pixel writer. Reads win while the FIFO
//   is below LOW_WM (counting reads still in flight); writes take the
//   remaining memory cycles.
// Ports:
//   clk, rst_n : pixel clock, asynchronous active-low reset
//   bus        : vga_fb_arbiter_if.slave
//                display : frame_start, pix_req -> pix_data, underflow, fifo_level
//                writer  : wr_req, wr_addr, wr_data -> wr_ack
//                memory  : mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata
// Optional: define FB_UNDERFLOW_CNT_EN for a saturating underflow_cnt[15:0].
//
// state   | meaning
// S_IDLE  | frame fully fetched; only writes are served
// S_FETCH | display reads and writes are arbitrated
module vga_fb_arbiter #(
  parameter int H_DISP     = 640,
  parameter int V_DISP     = 480,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WM     = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  vga_fb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int PIX_N = H_DISP * V_DISP;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_N - 1);
  localparam logic [ADDR_W:0]   PIX_N_X   = (ADDR_W+1)'(PIX_N);
  localparam logic [LVL_W:0]    DEPTH_X   = (LVL_W+1)'(FIFO_DEPTH);
  localparam logic [LVL_W:0]    LOW_WM_X  = (LVL_W+1)'(LOW_WM);

  typedef enum logic {S_IDLE = 1'b0, S_FETCH = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  count_q;
  // [0]: read strobe on the memory bus now; [1]: its data is on mem_rdata now
  logic [1:0]        rd_pipe_q;

  logic [DATA_W-1:0] pix_data_q;
  logic              underflow_q;
  logic              wr_ack_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic [LVL_W:0]    occ;
  logic              read_ok;
  logic              urgent;
  logic              grant_rd;
  logic              grant_wr;
  logic              wr_in_range;
  logic              pop;
  logic              push;
  logic              uf_ev;

  // Occupancy includes reads already issued, so the FIFO can never overflow.
  assign occ = (LVL_W+1)'(count_q) + (LVL_W+1)'(rd_pipe_q[0]) + (LVL_W+1)'(rd_pipe_q[1]);
  // No read is decided in the restart cycle: its address would be stale.
  assign read_ok     = (state_q == S_FETCH) && !bus.frame_start && (occ < DEPTH_X);
  assign urgent      = occ < LOW_WM_X;
  assign wr_in_range = {1'b0, bus.wr_addr} < PIX_N_X;

  assign pop   = bus.pix_req && (count_q != '0) && !bus.frame_start;
  assign uf_ev = bus.pix_req && ((count_q == '0) || bus.frame_start);
  assign push  = rd_pipe_q[1] && !bus.frame_start;

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    grant_rd  = 1'b0;
    grant_wr  = 1'b0;
    // wr_ack high means the held request was just served; skip it once.
    if (read_ok && urgent) begin
      grant_rd = 1'b1;
    end else if (bus.wr_req && !wr_ack_q) begin
      grant_wr = 1'b1;
    end else if (read_ok) begin
      grant_rd = 1'b1;
    end
    if (grant_rd) begin
      rd_addr_d = rd_addr_q + ADDR_W'(1);
      if (rd_addr_q == LAST_ADDR) begin
        state_d = S_IDLE;
      end
    end
    if (bus.frame_start) begin
      state_d   = S_FETCH;
      rd_addr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_pipe_q   <= 2'b00;
      pix_data_q  <= '0;
      underflow_q <= 1'b0;
      wr_ack_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      // Clearing the pipe marks every in-flight read as discarded.
      rd_pipe_q <= bus.frame_start ? 2'b00 : {rd_pipe_q[0], grant_rd};

      if (bus.frame_start) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        count_q <= count_q + LVL_W'(push) - LVL_W'(pop);
      end

      if (pop) begin
        pix_data_q <= fifo_mem[rd_ptr_q];
      end else if (uf_ev) begin
        pix_data_q <= '0;
      end
      underflow_q <= uf_ev;

      wr_ack_q <= grant_wr;
      mem_en_q <= grant_rd || (grant_wr && wr_in_range);
      mem_we_q <= grant_wr && wr_in_range;
      if (grant_rd) begin
        mem_addr_q <= rd_addr_q;
      end else if (grant_wr && wr_in_range) begin
        mem_addr_q  <= bus.wr_addr;
        mem_wdata_q <= bus.wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= bus.mem_rdata;
    end
  end

`ifdef FB_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_cnt_q <= '0;
    end else if (uf_ev && (underflow_cnt_q != 16'hFFFF)) begin
      underflow_cnt_q <= underflow_cnt_q + 16'd1;
    end
  end

  assign bus.underflow_cnt = underflow_cnt_q;
`endif

  assign bus.pix_data   = pix_data_q;
  assign bus.underflow  = underflow_q;
  assign bus.fifo_level = count_q;
  assign bus.wr_ack     = wr_ack_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter
//   Small frame (8x2, FIFO 4, watermark 2) with a RAM preloaded mem[a]=a.
//   A queue-based model predicts every output each cycle; directed phases
//   add hand-computed expectations for fill, streaming, writes, underflow,
//   restart and asynchronous reset.
`timescale 1ns/1ps
module tb_vga_fb_arbiter;
  localparam int H = 8, V = 2, AW = 5, DW = 24, DEPTH = 4, LWM = 2;
  localparam int NPIX = H * V;
  localparam int NMEM = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus ();

  vga_fb_arbiter #(
    .H_DISP(H), .V_DISP(V), .ADDR_W(AW), .DATA_W(DW),
    .FIFO_DEPTH(DEPTH), .LOW_WM(LWM)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  // Frame-buffer RAM: read data appears the cycle after the strobe.
  logic [DW-1:0] ram [NMEM];
  logic [DW-1:0] rdata_r;
  assign bus.mem_rdata = rdata_r;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NMEM; i++) ram[i] <= DW'(i);
      rdata_r <= '0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else rdata_r <= ram[bus.mem_addr];
    end
  end

  // Behavioural model: FIFO as a queue of pixels, reads in flight as a queue
  // of (value, cycle at which it lands).
  typedef struct { int val; int due; } infl_t;
  int    q[$];
  infl_t infl[$];
  int    shadow [NMEM];
  bit    m_fetch;
  int    m_raddr, cyc;
  bit    e_en, e_we, e_ack, e_uf;
  int    e_addr, e_wdata, e_pix, e_lvl, e_ucnt;

  always @(posedge clk or negedge rst_n) begin : model
    int cnt, pend, dec, v;
    bit can_rd;
    if (!rst_n) begin
      q.delete(); infl.delete();
      for (int i = 0; i < NMEM; i++) shadow[i] = i;
      m_fetch = 0; m_raddr = 0; cyc = 0;
      e_en = 0; e_we = 0; e_ack = 0; e_uf = 0;
      e_addr = 0; e_wdata = 0; e_pix = 0; e_lvl = 0; e_ucnt = 0;
    end else begin
      cnt = q.size();
      pend = infl.size();
      can_rd = m_fetch && !bus.frame_start && (cnt + pend < DEPTH);
      dec = 0;
      if (can_rd && (cnt + pend < LWM)) dec = 1;
      else if (bus.wr_req && !e_ack) dec = 2;
      else if (can_rd) dec = 1;
      e_en = 0; e_we = 0; e_ack = 0;
      if (dec == 2) begin
        e_ack = 1;
        if (int'(bus.wr_addr) < NPIX) begin
          e_en = 1; e_we = 1;
          e_addr = int'(bus.wr_addr);
          e_wdata = int'(bus.wr_data);
          shadow[e_addr] = e_wdata;
        end
      end else if (dec == 1) begin
        e_en = 1;
        e_addr = m_raddr;
        infl.push_back('{shadow[m_raddr], cyc + 2});
        if (m_raddr == NPIX - 1) m_fetch = 0;
        m_raddr++;
      end
      e_uf = 0;
      if (bus.pix_req && (bus.frame_start || cnt == 0)) begin
        e_pix = 0; e_uf = 1;
        if (e_ucnt < 65535) e_ucnt++;
      end else if (bus.pix_req) begin
        e_pix = q.pop_front();
      end
      if (infl.size() > 0 && infl[0].due == cyc) begin
        v = infl[0].val;
        void'(infl.pop_front());
        if (!bus.frame_start) q.push_back(v);
      end
      if (bus.frame_start) begin
        q.delete(); infl.delete();
        m_fetch = 1; m_raddr = 0;
      end
      e_lvl = q.size();
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("mem_en", 32'(bus.mem_en), 32'(e_en));
      if (e_en) begin
        chk("mem_we", 32'(bus.mem_we), 32'(e_we));
        chk("mem_addr", 32'(bus.mem_addr), e_addr);
        if (e_we) chk("mem_wdata", 32'(bus.mem_wdata), e_wdata);
      end
      chk("wr_ack", 32'(bus.wr_ack), 32'(e_ack));
      chk("pix_data", 32'(bus.pix_data), e_pix);
      chk("underflow", 32'(bus.underflow), 32'(e_uf));
      chk("fifo_level", 32'(bus.fifo_level), e_lvl);
`ifdef FB_UNDERFLOW_CNT_EN
      chk("underflow_cnt", 32'(bus.underflow_cnt), e_ucnt);
`endif
    end
  end

  // Observation logs for the directed phases.
  int rd_log[$], wr_log[$], wd_log[$], pix_log[$];
  bit acc_we[$];
  int en_cnt, n_ack, n_uf;
  logic preq_d;
  always @(posedge clk) preq_d <= bus.pix_req;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_en) begin
        en_cnt++;
        acc_we.push_back(bus.mem_we);
        if (bus.mem_we) begin
          wr_log.push_back(int'(bus.mem_addr));
          wd_log.push_back(int'(bus.mem_wdata));
        end else begin
          rd_log.push_back(int'(bus.mem_addr));
        end
      end
      if (bus.wr_ack) n_ack++;
      if (bus.underflow) n_uf++;
      if (preq_d) pix_log.push_back(int'(bus.pix_data));
    end
  end

  task automatic clear_logs();
    rd_log.delete(); wr_log.delete(); wd_log.delete(); pix_log.delete(); acc_we.delete();
    en_cnt = 0; n_ack = 0; n_uf = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic start_frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  // Holds wr_req until wr_ack is seen (bounded), then releases it.
  task automatic do_write(input int a, input int d);
    bit got;
    bus.wr_req = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = DW'(d);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.wr_ack) got = 1;
    end
    chk("wr_ack_seen", 32'(got), 1);
    tick();
    bus.wr_req = 1'b0;
  endtask

  int ucnt0;

  initial begin
    bus.frame_start = 1'b0;
    bus.pix_req = 1'b0;
    bus.wr_req = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    ucnt0 = 0;
    clear_logs();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pix_data", 32'(bus.pix_data), 0);
    chk("rst_underflow", 32'(bus.underflow), 0);
    chk("rst_fifo_level", 32'(bus.fifo_level), 0);
    chk("rst_wr_ack", 32'(bus.wr_ack), 0);
    chk("rst_mem_en", 32'(bus.mem_en), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    rst_n = 1'b1;
    run(3);
    chk("idle_no_access", en_cnt, 0);

    // Fill: reads 0..3, then FIFO full and memory quiet
    clear_logs();
    start_frame();
    run(12);
    chk("fill_reads", rd_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("fill_addr", rd_log[i], i);
    chk("fill_en_cnt", en_cnt, 4);
    chk("fill_level", 32'(bus.fifo_level), 4);

    // Streaming: 16 pops deliver 0..15 with no underflow
    clear_logs();
    bus.pix_req = 1'b1;
    run(16);
    bus.pix_req = 1'b0;
    run(4);
    chk("stream_len", pix_log.size(), 16);
    for (int i = 0; i < 16; i++) chk("stream_pix", pix_log[i], i);
    chk("stream_uf", n_uf, 0);
    chk("stream_reads", rd_log.size(), 12);
    clear_logs();
    run(8);
    chk("frame_done_no_reads", en_cnt, 0);
    chk("frame_done_level", 32'(bus.fifo_level), 0);

    // Write with FIFO full: one write, one ack cycle, no reads
    start_frame();
    run(10);
    clear_logs();
    do_write(5, 24'hABCDEF);
    run(3);
    chk("wr_ack_cycles", n_ack, 1);
    chk("wr_count", wr_log.size(), 1);
    chk("wr_addr", wr_log[0], 5);
    chk("wr_data", wd_log[0], 24'hABCDEF);
    chk("wr_only_access", en_cnt, 1);

    // Read before write while the FIFO is urgent
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    clear_logs();
    do_write(9, 24'h123456);
    run(2);
    chk("rbw_accesses", (acc_we.size() >= 3) ? 1 : 0, 1);
    chk("rbw_first_read", 32'(acc_we[0]), 0);
    chk("rbw_second_read", 32'(acc_we[1]), 0);
    chk("rbw_then_write", 32'(acc_we[2]), 1);
    chk("rbw_wr_addr", wr_log[0], 9);
    chk("rbw_ack_cycles", n_ack, 1);

    // Out-of-range write: ack only
    run(8);
    clear_logs();
    do_write(16, 24'h5A5A5A);
    run(2);
    chk("oor_ack_cycles", n_ack, 1);
    chk("oor_no_access", en_cnt, 0);

    // Underflow on empty FIFO
    start_frame();
    bus.pix_req = 1'b1;
`ifdef FB_UNDERFLOW_CNT_EN
    ucnt0 = int'(bus.underflow_cnt);
`endif
    tick();
    bus.pix_req = 1'b0;
    @(negedge clk);
    chk("uf_pulse", 32'(bus.underflow), 1);
    chk("uf_pix_zero", 32'(bus.pix_data), 0);
`ifdef FB_UNDERFLOW_CNT_EN
    chk("uf_cnt_inc", int'(bus.underflow_cnt), ucnt0 + 1);
`endif
    tick();
    chk("uf_one_cycle", 32'(bus.underflow), 0);

    // Mid-frame restart with a read in flight, pix_req in the restart cycle
    start_frame();
    tick();
    chk("restart_read_pending", 32'(bus.mem_en), 1);
    bus.frame_start = 1'b1;
    bus.pix_req = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    bus.pix_req = 1'b0;
    clear_logs();
    @(negedge clk);
    chk("restart_level0", 32'(bus.fifo_level), 0);
    chk("restart_uf", 32'(bus.underflow), 1);
    chk("restart_pix_zero", 32'(bus.pix_data), 0);
    tick();
    chk("restart_drop_a", 32'(bus.fifo_level), 0);
    tick();
    chk("restart_drop_b", 32'(bus.fifo_level), 0);
    tick();
    chk("restart_first_push", 32'(bus.fifo_level), 1);
    run(3);
    chk("restart_reads", (rd_log.size() >= 2) ? 1 : 0, 1);
    chk("restart_addr0", rd_log[0], 0);
    chk("restart_addr1", rd_log[1], 1);

    // Asynchronous reset mid-fetch
    start_frame();
    run(2);
    chk("pre_rst_mem_en", 32'(bus.mem_en), 1);
    chk("pre_rst_mem_addr", 32'(bus.mem_addr), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_mem_en", 32'(bus.mem_en), 0);
    chk("arst_mem_addr", 32'(bus.mem_addr), 0);
    chk("arst_fifo_level", 32'(bus.fifo_level), 0);
    chk("arst_pix_data", 32'(bus.pix_data), 0);
    chk("arst_wr_ack", 32'(bus.wr_ack), 0);
    chk("arst_underflow", 32'(bus.underflow), 0);
`ifdef FB_UNDERFLOW_CNT_EN
    chk("arst_ucnt", int'(bus.underflow_cnt), 0);
`endif
    run(2);
    rst_n = 1'b1;
    run(2);
    start_frame();
    run(10);
    chk("recover_level", 32'(bus.fifo_level), 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port frame-buffer RAM between the VGA display fetch and a pixel writer (handwriting canvas updates).
- The display side is fed through an internal prefetch FIFO. The FIFO is popped by the display timing's one-cycle-ahead pixel request, and registered pixel data is returned on the next cycle.
- Reads win whenever the FIFO is at risk. Writes use the spare memory cycles, in practice horizontal/vertical blanking.

Parameters:
- H_DISP, 640, visible pixels per line.
- V_DISP, 480, visible lines per frame.
- ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W >= H_DISP*V_DISP.
- DATA_W, 24, pixel width.
- FIFO_DEPTH, 16, prefetch FIFO entries; power of two, >= 4.
- LOW_WM, 8, read-urgent threshold; 1 <= LOW_WM < FIFO_DEPTH.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse before the first visible line; restarts the fetch.
- pix_req  in  1  display consumes one pixel this cycle.
- pix_data  out  DATA_W  pixel for the previous cycle's pix_req.
- underflow  out  1  one-cycle pulse: pix_req arrived while the FIFO was empty.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- wr_req  in  1  writer requests one pixel write; held until wr_ack.
- wr_addr  in  ADDR_W  write address (linear, y*H_DISP+x).
- wr_data  in  DATA_W  write pixel.
- wr_ack  out  1  one-cycle pulse: write accepted.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  read data, valid in the cycle after a read strobe.

Behaviour:
- Reset: all outputs 0 except fifo_level; fifo_level 0; FIFO empty; rd_addr 0; state IDLE.
- States:
  - IDLE: no reads; writes are served.
  - FETCH: reads and writes are arbitrated.
  - frame_start in any state: go to FETCH, rd_addr=0, FIFO flushed (pointers and count 0), pending reads marked discard.
  - FETCH to IDLE: in the cycle the read of address H_DISP*V_DISP-1 is decided.
- Pipeline:
  - The arbitration decision at cycle t drives the registered mem_* outputs at t+1.
  - Read data is sampled and pushed at t+2.
  - pending (0..2) = reads decided but not yet pushed.
  - space = FIFO_DEPTH - count - pending.
- Arbitration, per cycle, at most one access:
  1. If FETCH, space>0 and count+pending < LOW_WM: read.
  2. Else if wr_req and wr_ack==0: write.
  3. Else if FETCH and space>0: read.
  4. Else idle, mem_en=0.
- Write starvation during sustained active-line consumption is accepted by design.
- Reads: mem_addr=rd_addr, then rd_addr increments.
- Writes:
  - wr_ack is asserted in the same cycle as mem_en&mem_we.
  - A write is never granted while wr_ack is high, which prevents a double write of a held request.
  - wr_addr >= H_DISP*V_DISP: acked (wr_ack pulse) with no memory access.
- FIFO:
  - Simultaneous push and pop leaves count unchanged.
  - Pop on pix_req when count>0: pix_data <= head at the next edge.
  - Pop with count==0: pix_data <= 0, underflow pulses the next cycle, pointers unchanged.
  - Without a pop, pix_data holds.
- Flush interactions:
  - Read data returning in the same cycle as frame_start, or returning for a read decided before it, is discarded.
  - pix_req in the frame_start cycle behaves as pix_req on an empty FIFO.
- Push never overflows: space is guaranteed by the reservation.

Optional Feature:
- Macro FB_UNDERFLOW_CNT_EN.
- Defined: adds output underflow_cnt [15:0], a saturating count of underflow events (saturates at 16'hFFFF). Reset 0; not cleared by frame_start.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Common parameters: H_DISP=8, V_DISP=2, FIFO_DEPTH=4, LOW_WM=2; memory preloaded with mem[a]=a.
- Fill: frame_start, no pix_req -> reads at addresses 0,1,2,3; fifo_level settles at 4; mem_en then stays 0.
- Streaming: after fill, pix_req held for 16 cycles -> pix_data sequence 0..15, one per cycle starting the cycle after the first pix_req; no underflow; state IDLE after the address-15 read is decided.
- Write arbitration: FIFO full, wr_req addr=5 data=0xABCDEF -> mem_we=1, mem_addr=5, wr_ack for exactly one cycle. With wr_req held while fifo_level=1 -> a read is issued before the write.
- Out-of-range write: wr_addr=16 -> wr_ack pulse, mem_en stays 0.
- Underflow: pix_req with fifo_level=0 -> pix_data=0 and underflow=1 the next cycle. With FB_UNDERFLOW_CNT_EN defined, underflow_cnt increments by 1.
- Mid-frame restart: frame_start while a read is pending -> the returned data is dropped, fifo_level=0, and the next reads start at address 0. Async rst_n low mid-fetch -> all outputs 0 immediately.
